// File: rtl/comp_offset_cal.sv
// SAR offset-calibration controller for the RX synchronous comparator: trials each
// offset_code bit MSB-first and keeps it when the zero-input comparator reads mostly ones.
module comp_offset_cal #(
  parameter int OFFSET_BITS = 4,
  parameter int WIN_LOG2    = 3,
  parameter int SETTLE_CYC  = 2,
  parameter logic [OFFSET_BITS-1:0] OFFSET_RESET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   comp_out,
  output logic                   cal_en,
  output logic [OFFSET_BITS-1:0] offset_code,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = (OFFSET_BITS > 1) ? $clog2(OFFSET_BITS) : 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [WIN_LOG2:0] HALF = (WIN_LOG2+1)'(2 ** (WIN_LOG2 - 1));

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DECIDE, DONE} state_t;

  state_t                 state, state_next;
  logic [OFFSET_BITS-1:0] code_next, saved_code, saved_next;
  logic                   cal_en_next, busy_next, done_next;
  logic [IDX_W-1:0]       bit_idx, idx_next;
  logic [SET_W-1:0]       settle_cnt, settle_next;
  logic [WIN_LOG2-1:0]    win_cnt, win_next;
  logic [WIN_LOG2:0]      ones_cnt, ones_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      offset_code <= OFFSET_RESET;
      saved_code  <= '0;
      cal_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bit_idx     <= '0;
      settle_cnt  <= '0;
      win_cnt     <= '0;
      ones_cnt    <= '0;
    end else begin
      state       <= state_next;
      offset_code <= code_next;
      saved_code  <= saved_next;
      cal_en      <= cal_en_next;
      busy        <= busy_next;
      done        <= done_next;
      bit_idx     <= idx_next;
      settle_cnt  <= settle_next;
      win_cnt     <= win_next;
      ones_cnt    <= ones_next;
    end
  end

  always_comb begin
    state_next  = state;
    code_next   = offset_code;
    saved_next  = saved_code;
    cal_en_next = cal_en;
    busy_next   = busy;
    done_next   = 1'b0;
    idx_next    = bit_idx;
    settle_next = settle_cnt;
    win_next    = win_cnt;
    ones_next   = ones_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          saved_next                 = offset_code;
          idx_next                   = IDX_W'(OFFSET_BITS - 1);
          code_next                  = '0;
          code_next[OFFSET_BITS-1]   = 1'b1;
          cal_en_next                = 1'b1;
          busy_next                  = 1'b1;
          settle_next                = '0;
          state_next                 = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
          win_next   = '0;
          ones_next  = '0;
          state_next = MEASURE;
        end else begin
          settle_next = settle_cnt + 1'b1;
        end
      end
      MEASURE: begin
        ones_next = ones_cnt + (WIN_LOG2+1)'(comp_out);
        if (win_cnt == '1) state_next = DECIDE;
        else               win_next   = win_cnt + 1'b1;
      end
      DECIDE: begin
        // A tie (exactly half ones) counts as "not above zero" and clears the bit.
        if (ones_cnt <= HALF) code_next[bit_idx] = 1'b0;
        if (bit_idx != '0) begin
          idx_next                         = bit_idx - 1'b1;
          code_next[bit_idx - IDX_W'(1)]   = 1'b1;
          settle_next                      = '0;
          state_next                       = SETTLE;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_next   = 1'b1;
        busy_next   = 1'b0;
        cal_en_next = 1'b0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (abort && (state == SETTLE || state == MEASURE || state == DECIDE)) begin
      state_next  = IDLE;
      code_next   = saved_code;
      cal_en_next = 1'b0;
      busy_next   = 1'b0;
      done_next   = 1'b0;
    end
  end

endmodule

// File: tb/tb_comp_offset_cal.sv
// Randomized bench for comp_offset_cal: a threshold comparator model drives comp_out and a
// plain binary-search model predicts trial codes, result and done timing.
module tb_comp_offset_cal;
  localparam int NB = 4;
  localparam int DONE_EDGE = 1 + NB * (2 + 8 + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          comp_out = 1'b0;
  logic          cal_en, busy, done;
  logic [NB-1:0] offset_code;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  int thr = 0;

  always #5 clk = ~clk;

  comp_offset_cal #(.OFFSET_BITS(NB), .WIN_LOG2(3), .SETTLE_CYC(2), .OFFSET_RESET('0)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .comp_out(comp_out),
    .cal_en(cal_en), .offset_code(offset_code), .busy(busy), .done(done)
  );

  // Comparator stand-in: 0 const low, 1 const high, 2 ones below threshold, 3 alternating.
  always @(negedge clk) begin
    case (mode)
      0:       comp_out = 1'b0;
      1:       comp_out = 1'b1;
      2:       comp_out = (int'(offset_code) < thr);
      default: comp_out = ~comp_out;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // t is the comparator threshold the model assumes: a trial code is kept iff code < t.
  task automatic run_cal(input int m, input int t, input bit restart, input bit abort_too);
    int trial[NB];
    int code, done_edge, done_cnt, drop;
    code = 0;
    for (int b = NB - 1; b >= 0; b--) begin
      trial[NB-1-b] = code | (1 << b);
      if (trial[NB-1-b] < t) code = trial[NB-1-b];
    end
    mode = m;
    thr  = t;
    @(negedge clk);
    start = 1'b1;
    abort = abort_too;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("cal_en_after_start", cal_en, 1);
    done_edge = -1;
    done_cnt  = 0;
    drop      = 0;
    for (int e = 1; e <= 60; e++) begin
      if (restart && e == 20) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < NB; i++)
        if (e == 11 * i + 5) chk($sformatf("trial%0d", i), offset_code, trial[i]);
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
      if (e < DONE_EDGE && (!cal_en || !busy)) drop++;
    end
    chk("done_edge", done_edge, DONE_EDGE);
    chk("done_count", done_cnt, 1);
    chk("busy_cal_en_held", drop, 0);
    chk("result_code", offset_code, code);
    chk("busy_idle", busy, 0);
    chk("cal_en_idle", cal_en, 0);
    $display("cal mode=%0d thr=%0d restart=%0d result=%0d expected=%0d done_edge=%0d",
             m, t, restart, offset_code, code, done_edge);
  endtask

  initial begin
    int dcnt;
    #12;
    chk("reset_cal_en", cal_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_code", offset_code, 0);
    @(negedge clk);
    rst = 1'b1;

    run_cal(1, 16, 1'b0, 1'b0);   // always ones -> 15
    run_cal(0, 0, 1'b0, 1'b0);    // always zeros -> 0
    run_cal(2, 6, 1'b0, 1'b0);    // threshold 6 -> 5
    run_cal(3, 0, 1'b0, 1'b0);    // alternating tie -> 0
    run_cal(2, 11, 1'b1, 1'b1);   // restart while busy, abort with start in IDLE
    for (int r = 0; r < 6; r++) run_cal(2, int'($urandom_range(0, 16)), 1'b0, 1'b0);

    // Abort in the second MEASURE window restores the preloaded code.
    run_cal(2, 10, 1'b0, 1'b0);
    chk("preload_code", offset_code, 9);
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      if (e == 16) abort = 1'b1;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cal_en", cal_en, 0);
    chk("abort_code", offset_code, 9);
    dcnt = 0;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_code_held", offset_code, 9);
    $display("abort test code=%0d done_pulses=%0d", offset_code, dcnt);

    // Asynchronous reset in the middle of MEASURE.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_cal_en", cal_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_code", offset_code, 0);
    @(negedge clk);
    rst = 1'b1;
    dcnt = 0;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("rst_quiet", dcnt, 0);
    $display("reset test code=%0d activity=%0d", offset_code, dcnt);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
